// File: rtl/nanci_seq_ctrl.sv
// Nanci PE-mesh instruction sequencer.
// Steps through a small program memory and broadcasts one opcode per cycle to
// every PE. Each instruction repeats for its programmed cycle count.
// Instruction word: {last, op[OP_WIDTH-1:0], rep[REP_WIDTH-1:0]}.
module nanci_seq_ctrl #(
   parameter int unsigned PROG_DEPTH = 16,
   parameter int unsigned PC_WIDTH   = 4,
   parameter int unsigned OP_WIDTH   = 4,
   parameter int unsigned REP_WIDTH  = 8,
   parameter int unsigned INSTR_W    = OP_WIDTH + REP_WIDTH + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_hold,
   input  logic                i_prog_we,
   input  logic [PC_WIDTH-1:0] i_prog_addr,
   input  logic [INSTR_W-1:0]  i_prog_data,
   output logic [OP_WIDTH-1:0] o_op,
   output logic                o_op_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic [PC_WIDTH-1:0] o_pc
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [PC_WIDTH-1:0] PC_LAST     = PC_WIDTH'(PROG_DEPTH - 1);
   localparam logic [OP_WIDTH-1:0] OP_LAST_DEF = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_NOP      = '0;

   logic [INSTR_W-1:0]   mem [PROG_DEPTH];
   logic [INSTR_W-1:0]   rd_q;

   logic [1:0]           state,    state_nxt;
   logic [PC_WIDTH-1:0]  pc,       pc_nxt;
   logic [REP_WIDTH-1:0] rep_cnt,  rep_nxt;
   logic [OP_WIDTH-1:0]  op_q,     op_nxt;
   logic                 last_q,   last_nxt;
   logic                 err_q,    err_nxt;

   logic                 rd_last;
   logic [OP_WIDTH-1:0]  rd_op;
   logic [REP_WIDTH-1:0] rd_rep;

   assign rd_last = rd_q[INSTR_W-1];
   assign rd_op   = rd_q[INSTR_W-2 -: OP_WIDTH];
   assign rd_rep  = rd_q[REP_WIDTH-1:0];

   // Program memory: writes only while idle; the read port is addressed by the
   // next pc so rd_q already holds mem[pc] during the FETCH cycle.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && i_prog_we) begin
         mem[i_prog_addr] <= i_prog_data;
      end
      rd_q <= mem[pc_nxt];
   end

   // Next-state logic for the sequencer.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      rep_nxt   = rep_cnt;
      op_nxt    = op_q;
      last_nxt  = last_q;
      err_nxt   = err_q;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               pc_nxt    = '0;
               err_nxt   = 1'b0;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rd_op > OP_LAST_DEF) begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (rd_rep == '0) begin
               // Zero-repeat instruction: advance exactly as at the end of ISSUE.
               if (rd_last || pc == PC_LAST) begin
                  state_nxt = ST_DONE;
               end else begin
                  pc_nxt    = pc + PC_WIDTH'(1);
                  state_nxt = ST_FETCH;
               end
            end else begin
               rep_nxt   = rd_rep;
               op_nxt    = rd_op;
               last_nxt  = rd_last;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!i_hold) begin
               rep_nxt = rep_cnt - REP_WIDTH'(1);
               if (rep_cnt == REP_WIDTH'(1)) begin
                  if (last_q || pc == PC_LAST) begin
                     state_nxt = ST_DONE;
                  end else begin
                     pc_nxt    = pc + PC_WIDTH'(1);
                     state_nxt = ST_FETCH;
                  end
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pc      <= '0;
         rep_cnt <= '0;
         op_q    <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         rep_cnt <= rep_nxt;
         op_q    <= op_nxt;
         last_q  <= last_nxt;
         err_q   <= err_nxt;
      end
   end

   assign o_op       = op_q;
   assign o_op_valid = (state == ST_ISSUE) && (op_q != OP_NOP) && !i_hold;
   assign o_busy     = (state != ST_IDLE);
   assign o_done     = (state == ST_DONE);
   assign o_err      = err_q;
   assign o_pc       = pc;

endmodule

// File: tb/tb_nanci_seq_ctrl.sv
// Directed self-checking bench for nanci_seq_ctrl.
module tb_nanci_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic        i_hold;
   logic        i_prog_we;
   logic [3:0]  i_prog_addr;
   logic [12:0] i_prog_data;
   logic [3:0]  o_op;
   logic        o_op_valid;
   logic        o_busy;
   logic        o_done;
   logic        o_err;
   logic [3:0]  o_pc;

   int n_checks = 0;
   int n_fails  = 0;

   nanci_seq_ctrl #(
      .PROG_DEPTH (16),
      .PC_WIDTH   (4),
      .OP_WIDTH   (4),
      .REP_WIDTH  (8),
      .INSTR_W    (13)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_hold      (i_hold),
      .i_prog_we   (i_prog_we),
      .i_prog_addr (i_prog_addr),
      .i_prog_data (i_prog_data),
      .o_op        (o_op),
      .o_op_valid  (o_op_valid),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_pc        (o_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog_wr(input logic [3:0] addr, input logic [12:0] data);
      i_prog_we   = 1'b1;
      i_prog_addr = addr;
      i_prog_data = data;
      step();
      i_prog_we   = 1'b0;
   endtask

   // Start a run and observe it cycle by cycle; c=1 is the cycle after the start edge.
   task automatic run(input int max_c, input int hold_from, input int hold_len,
                      input bit keep_start, input bit we_busy,
                      output int nval, output logic [63:0] vmask, output logic [31:0] ops,
                      output int done_c, output int end_c, output logic [3:0] pc_done);
      nval = 0; vmask = '0; ops = '0; done_c = 0; end_c = 0; pc_done = '0;
      i_start = 1'b1;
      for (int c = 1; c <= max_c; c++) begin
         step();
         i_start     = keep_start && (c <= 4);
         i_hold      = (c >= hold_from) && (c < hold_from + hold_len);
         i_prog_we   = we_busy && (c <= 4);
         i_prog_addr = 4'd0;
         i_prog_data = 13'h1F05;
         #1;
         if (o_op_valid) begin
            nval++;
            vmask[c] = 1'b1;
            ops = {ops[27:0], o_op};
         end
         if (o_done) begin
            done_c  = c;
            pc_done = o_pc;
         end
         if (!o_busy) begin
            end_c = c;
            break;
         end
      end
      i_start = 1'b0; i_hold = 1'b0; i_prog_we = 1'b0;
      if (end_c == 0) check("run_timeout", 64'd0, 64'd1);
   endtask

   int          nval, done_c, end_c;
   logic [63:0] vmask;
   logic [31:0] ops;
   logic [3:0]  pc_done;

   initial begin
      rst = 1'b1; i_start = 1'b0; i_hold = 1'b0;
      i_prog_we = 1'b0; i_prog_addr = '0; i_prog_data = '0;

      // 1: reset
      step(); step();
      check("rst_busy",  64'(o_busy),     64'd0);
      check("rst_valid", 64'(o_op_valid), 64'd0);
      check("rst_done",  64'(o_done),     64'd0);
      check("rst_err",   64'(o_err),      64'd0);
      check("rst_pc",    64'(o_pc),       64'd0);
      rst = 1'b0;
      step();

      // 2: single instruction {1,0001,3}
      prog_wr(4'd0, 13'h1103);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t2_nval",  64'(nval),   64'd3);
      check("t2_vmask", vmask,       64'h1C);
      check("t2_ops",   64'(ops),    64'h111);
      check("t2_done",  64'(done_c), 64'd5);
      check("t2_end",   64'(end_c),  64'd6);
      check("t2_op_hold_idle", 64'(o_op), 64'd1);

      // 4: hold two cycles mid-issue
      run(20, 3, 2, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t4_nval",  64'(nval),   64'd3);
      check("t4_vmask", vmask,       64'h64);
      check("t4_done",  64'(done_c), 64'd7);

      // hold in FETCH and in DONE has no effect
      run(20, 1, 1, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("hold_fetch_vmask", vmask,       64'h1C);
      check("hold_fetch_done",  64'(done_c), 64'd5);
      run(20, 5, 1, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("hold_done_end", 64'(end_c), 64'd6);

      // 6: reset during ISSUE, then replay
      i_start = 1'b1;
      step(); i_start = 1'b0;
      step(); #1;
      check("t6_valid_pre", 64'(o_op_valid), 64'd1);
      step();
      rst = 1'b1;
      step();
      check("t6_busy",  64'(o_busy),     64'd0);
      check("t6_valid", 64'(o_op_valid), 64'd0);
      check("t6_op",    64'(o_op),       64'd0);
      check("t6_pc",    64'(o_pc),       64'd0);
      check("t6_done",  64'(o_done),     64'd0);
      rst = 1'b0;
      step();
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t6_replay_nval", 64'(nval),   64'd3);
      check("t6_replay_done", 64'(done_c), 64'd5);

      // 3: two instructions; start and program writes while busy are ignored
      prog_wr(4'd0, 13'h0102);
      prog_wr(4'd1, 13'h1301);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t3_vmask", vmask,       64'h2C);
      check("t3_ops",   64'(ops),    64'h113);
      check("t3_done",  64'(done_c), 64'd6);
      run(20, 0, 0, 1'b1, 1'b1, nval, vmask, ops, done_c, end_c, pc_done);
      check("busy_start_vmask", vmask,      64'h2C);
      check("busy_start_end",   64'(end_c), 64'd7);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("busy_we_ops", 64'(ops),   64'h113);
      check("busy_we_err", 64'(o_err), 64'd0);

      // zero-repeat instruction is skipped
      prog_wr(4'd0, 13'h0100);
      prog_wr(4'd1, 13'h1402);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("skip_vmask", vmask,       64'h18);
      check("skip_ops",   64'(ops),    64'h44);
      check("skip_done",  64'(done_c), 64'd5);

      // NOP issues without valid
      prog_wr(4'd0, 13'h1002);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("nop_nval", 64'(nval),   64'd0);
      check("nop_done", 64'(done_c), 64'd4);

      // 5: reserved opcode aborts, then a valid run clears the error
      prog_wr(4'd0, 13'h0904);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t5_err",  64'(o_err),  64'd1);
      check("t5_done", 64'(done_c), 64'd0);
      check("t5_end",  64'(end_c),  64'd2);
      check("t5_nval", 64'(nval),   64'd0);
      prog_wr(4'd0, 13'h1103);
      run(20, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("t5_clr_err",  64'(o_err), 64'd0);
      check("t5_clr_nval", 64'(nval),  64'd3);

      // no last bit anywhere: the final slot ends the program without wrapping
      for (int i = 0; i < 16; i++) prog_wr(4'(i), 13'h0201);
      run(60, 0, 0, 1'b0, 1'b0, nval, vmask, ops, done_c, end_c, pc_done);
      check("full_nval",    64'(nval),    64'd16);
      check("full_done",    64'(done_c),  64'd33);
      check("full_end",     64'(end_c),   64'd34);
      check("full_pc_done", 64'(pc_done), 64'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
